// File: rtl/switch_debouncer.sv
// Per-bit switch debouncer: two-flop synchronizer, a stable-cycle counter per bit,
// one-cycle change pulses and an 8-bit wrapping count of cycles with any change.
module switch_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] changed,
  output logic             any_change,
  output logic [7:0]       event_count
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sw_meta;
  logic [WIDTH-1:0] sw_sync;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] sw_out_next;
  logic [WIDTH-1:0] changed_next;

  // A bit only updates after DEBOUNCE_CYCLES consecutive disagreeing samples;
  // any agreeing sample throws the partial count away.
  always_comb begin
    sw_out_next  = sw_out;
    changed_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sw_sync[i] != sw_out[i]) begin
        if (cnt[i] == CNT_LAST) begin
          sw_out_next[i]  = sw_sync[i];
          changed_next[i] = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta     <= '0;
      sw_sync     <= '0;
      sw_out      <= '0;
      changed     <= '0;
      event_count <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
      sw_out  <= sw_out_next;
      changed <= changed_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
      if (any_change) begin
        event_count <= event_count + 8'd1;
      end
    end
  end

  assign any_change = |changed;

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomized and directed bench for switch_debouncer (WIDTH=8, DEBOUNCE_CYCLES=4),
// checked against a sample-history reference model.
module tb_switch_debouncer;

  localparam int WIDTH = 8;
  localparam int DC    = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] SW;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] changed;
  logic             any_change;
  logic [7:0]       event_count;

  int vectors;
  int miscompares;

  // Reference model: a bit flips when the last DC synchronized samples all disagree with it
  logic [WIDTH-1:0] hist [$];
  logic [WIDTH-1:0] m_out;
  logic [WIDTH-1:0] m_chg;
  logic [7:0]       m_cnt;

  switch_debouncer #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DC)) dut (
    .clk         (clk),
    .reset       (reset),
    .SW          (SW),
    .sw_out      (sw_out),
    .changed     (changed),
    .any_change  (any_change),
    .event_count (event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    hist.delete();
    m_out = '0;
    m_chg = '0;
    m_cnt = '0;
  endtask

  task automatic model_edge(input logic [WIDTH-1:0] sw_now);
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] h;
    int n;
    bit all_differ;
    if (m_chg != '0) m_cnt = m_cnt + 8'd1;
    hist.push_back(sw_now);
    n = hist.size();
    flip = '0;
    if (n - 3 - (DC - 1) >= 0) begin
      for (int b = 0; b < WIDTH; b++) begin
        all_differ = 1'b1;
        for (int j = 0; j < DC; j++) begin
          h = hist[n - 3 - j];
          if (h[b] == m_out[b]) all_differ = 1'b0;
        end
        flip[b] = all_differ;
      end
    end
    m_out = m_out ^ flip;
    m_chg = flip;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(SW);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    SW = '0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({sw_out, changed, any_change, event_count} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got out=%h chg=%h any=%b cnt=%0d, expected all zero",
               sw_out, changed, any_change, event_count);
    end
    tick();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      vectors++;
      if ({sw_out, changed, any_change, event_count} !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_idle cycle %0d: got out=%h chg=%h any=%b cnt=%0d, expected all zero",
                 c, sw_out, changed, any_change, event_count);
      end
    end
  endtask

  task automatic test_step_a5();
    apply_reset();
    SW = 8'hA5;
    for (int e = 1; e <= 9; e++) begin
      tick();
      vectors++;
      if ({sw_out, changed, any_change, event_count} !== {m_out, m_chg, |m_chg, m_cnt}) begin
        miscompares++;
        $display("[TB] FAIL step_a5 edge %0d: got out=%h chg=%h any=%b cnt=%0d, expected out=%h chg=%h any=%b cnt=%0d",
                 e, sw_out, changed, any_change, event_count, m_out, m_chg, |m_chg, m_cnt);
      end
      if (e == 5) begin
        vectors++;
        if (sw_out !== 8'h00) begin
          miscompares++;
          $display("[TB] FAIL step_a5_early: got out=%h, expected 00", sw_out);
        end
      end
      if (e == 6) begin
        vectors++;
        if ({sw_out, changed} !== {8'hA5, 8'hA5}) begin
          miscompares++;
          $display("[TB] FAIL step_a5_edge6: got out=%h chg=%h, expected out=a5 chg=a5", sw_out, changed);
        end
      end
      if (e == 7) begin
        vectors++;
        if ({changed, event_count} !== {8'h00, 8'd1}) begin
          miscompares++;
          $display("[TB] FAIL step_a5_edge7: got chg=%h cnt=%0d, expected chg=00 cnt=1", changed, event_count);
        end
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    SW = 8'h01;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 3) SW = 8'h00;
      vectors++;
      if ({sw_out, changed, any_change, event_count} !== {m_out, m_chg, |m_chg, m_cnt}) begin
        miscompares++;
        $display("[TB] FAIL glitch edge %0d: got out=%h chg=%h any=%b cnt=%0d, expected out=%h chg=%h any=%b cnt=%0d",
                 e, sw_out, changed, any_change, event_count, m_out, m_chg, |m_chg, m_cnt);
      end
      vectors++;
      if ({sw_out, changed, event_count} !== '0) begin
        miscompares++;
        $display("[TB] FAIL glitch_quiet edge %0d: got out=%h chg=%h cnt=%0d, expected all zero",
                 e, sw_out, changed, event_count);
      end
    end
  endtask

  task automatic test_bounce();
    int pulses;
    pulses = 0;
    apply_reset();
    for (int e = 1; e <= 16; e++) begin
      if (e <= 10) SW = ((((e - 1) / 2) % 2) == 0) ? 8'h02 : 8'h00;
      else SW = 8'h02;
      tick();
      if (changed[1] === 1'b1) pulses++;
      vectors++;
      if ({sw_out, changed, any_change, event_count} !== {m_out, m_chg, |m_chg, m_cnt}) begin
        miscompares++;
        $display("[TB] FAIL bounce edge %0d: got out=%h chg=%h any=%b cnt=%0d, expected out=%h chg=%h any=%b cnt=%0d",
                 e, sw_out, changed, any_change, event_count, m_out, m_chg, |m_chg, m_cnt);
      end
      if (e == 13 || e == 14) begin
        vectors++;
        if (sw_out[1] !== ((e == 14) ? 1'b1 : 1'b0)) begin
          miscompares++;
          $display("[TB] FAIL bounce_settle edge %0d: got sw_out[1]=%b, expected %b", e, sw_out[1], e == 14);
        end
      end
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("[TB] FAIL bounce_pulses: got %0d changed[1] pulses, expected 1", pulses);
    end
  endtask

  task automatic test_reset_midcount();
    apply_reset();
    SW = 8'hFF;
    for (int e = 1; e <= 4; e++) tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({sw_out, changed, any_change, event_count} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midcount_async: got out=%h chg=%h any=%b cnt=%0d, expected all zero",
               sw_out, changed, any_change, event_count);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if ({sw_out, changed, event_count} !== '0) begin
        miscompares++;
        $display("[TB] FAIL midcount_held cycle %0d: got out=%h chg=%h cnt=%0d, expected all zero",
                 c, sw_out, changed, event_count);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      vectors++;
      if ({sw_out, changed, any_change, event_count} !== {m_out, m_chg, |m_chg, m_cnt}) begin
        miscompares++;
        $display("[TB] FAIL midcount edge %0d: got out=%h chg=%h any=%b cnt=%0d, expected out=%h chg=%h any=%b cnt=%0d",
                 e, sw_out, changed, any_change, event_count, m_out, m_chg, |m_chg, m_cnt);
      end
      if (e == 5 || e == 6) begin
        vectors++;
        if (sw_out !== ((e == 6) ? 8'hFF : 8'h00)) begin
          miscompares++;
          $display("[TB] FAIL midcount_latency edge %0d: got out=%h", e, sw_out);
        end
      end
    end
    vectors++;
    if (event_count !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL midcount_events: got %0d, expected 1", event_count);
    end
  endtask

  task automatic test_random();
    int hold;
    apply_reset();
    for (int s = 0; s < 60; s++) begin
      SW = WIDTH'($urandom);
      hold = $urandom_range(1, 7);
      for (int c = 0; c < hold; c++) begin
        tick();
        vectors++;
        if ({sw_out, changed, any_change, event_count} !== {m_out, m_chg, |m_chg, m_cnt}) begin
          miscompares++;
          $display("[TB] FAIL random seg %0d cycle %0d: got out=%h chg=%h any=%b cnt=%0d, expected out=%h chg=%h any=%b cnt=%0d",
                   s, c, sw_out, changed, any_change, event_count, m_out, m_chg, |m_chg, m_cnt);
        end
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int s = 0; s < 256; s++) begin
      SW = (s % 2 == 0) ? 8'h01 : 8'h00;
      for (int c = 0; c < 10; c++) begin
        tick();
        vectors++;
        if ({sw_out, changed, any_change, event_count} !== {m_out, m_chg, |m_chg, m_cnt}) begin
          miscompares++;
          $display("[TB] FAIL wrap step %0d cycle %0d: got out=%h chg=%h any=%b cnt=%0d, expected out=%h chg=%h any=%b cnt=%0d",
                   s, c, sw_out, changed, any_change, event_count, m_out, m_chg, |m_chg, m_cnt);
        end
      end
    end
    vectors++;
    if ({sw_out, event_count} !== {8'h00, 8'd0}) begin
      miscompares++;
      $display("[TB] FAIL wrap_final: got out=%h cnt=%0d, expected out=00 cnt=0", sw_out, event_count);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    SW          = '0;
    model_reset();
    test_reset();
    test_step_a5();
    test_glitch();
    test_bounce();
    test_reset_midcount();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of switch inputs debounced.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before an output update (legal range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port SW, input, WIDTH bits: raw asynchronous board switch levels.
REQ-006 The block SHALL have port sw_out, output, WIDTH bits: debounced switch levels, fed to the downstream switch-to-LED logic.
REQ-007 The block SHALL have port changed, output, WIDTH bits: per-bit one-cycle pulse marking an sw_out update.
REQ-008 The block SHALL have port any_change, output, 1 bit: OR of changed.
REQ-009 The block SHALL have port event_count, output, 8 bits: count of cycles in which any_change was high.

Function
REQ-010 SW SHALL pass through a two-flop synchronizer (sw_meta, then sw_sync) before any other use.
REQ-011 Each bit i SHALL have an independent counter cnt[i] of width clog2(DEBOUNCE_CYCLES+1), minimum 1 bit.
REQ-012 If sw_sync[i] equals sw_out[i] on an edge, cnt[i] SHALL be cleared to 0.
REQ-013 If sw_sync[i] differs from sw_out[i] and cnt[i] is less than DEBOUNCE_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-014 If sw_sync[i] differs and cnt[i] equals DEBOUNCE_CYCLES-1, then on the same edge sw_out[i] SHALL load sw_sync[i], cnt[i] SHALL clear, and changed[i] SHALL be set.
REQ-015 changed[i] SHALL be high for exactly the one cycle following the sw_out[i] update and low otherwise.
REQ-016 Latency: with SW[i] stable at its new level before edge 1, sw_out[i] SHALL take the new value after edge DEBOUNCE_CYCLES+2.
REQ-017 A disagreement on sw_sync[i] lasting fewer than DEBOUNCE_CYCLES cycles SHALL produce no sw_out or changed activity, and cnt[i] SHALL restart from 0.
REQ-018 Bits SHALL be fully independent; simultaneous qualification of several bits SHALL update all of them on the same edge and set multiple changed bits in one cycle.
REQ-019 any_change SHALL be combinational OR of changed.
REQ-020 event_count SHALL increment by exactly 1 on each edge where any_change is high, regardless of how many changed bits are set.
REQ-021 event_count SHALL wrap from 255 to 0.
REQ-022 sw_out, changed and event_count SHALL be registered outputs.

Reset
REQ-023 While reset is high, sw_meta, sw_sync, sw_out, changed, every cnt[i] and event_count SHALL be 0, asynchronously and independent of clk.
REQ-024 Reset asserted mid-count SHALL discard the partial count; after release, qualification SHALL restart from cnt=0 through the full synchronizer latency.
REQ-025 A switch held high through reset SHALL be debounced from sw_out=0 after release, producing a normal changed pulse and an event_count increment.

Verification (DEBOUNCE_CYCLES=4, WIDTH=8)
REQ-026 Reset with SW=0x00 -> sw_out=0x00, changed=0x00, event_count=0, with no activity for 20 cycles after release.
REQ-027 SW steps 0x00 to 0xA5 and holds -> sw_out=0xA5 after edge 6, changed=0xA5 for one cycle, any_change high for one cycle, event_count=1.
REQ-028 SW[0] high for 3 cycles, then low -> sw_out stays 0x00, changed stays 0x00, event_count is unchanged.
REQ-029 SW[1] toggles every 2 cycles for 10 cycles, then holds 1 -> exactly one changed[1] pulse, with sw_out[1]=1 six edges after the final settle.
REQ-030 Reset pulsed when cnt=2 on an 0x00-to-0xFF step, with SW still 0xFF -> outputs zero during reset; sw_out=0xFF six edges after release; event_count=1.
REQ-031 256 alternating 0x00/0x01 steps, each held 10 cycles -> event_count wraps to 0, and sw_out always equals the pre-step SW value delayed by 6 edges.
